// File: rtl/trisc_datapath_pkg.sv
//------------------------------------------------------------------------------
// Module  : trisc_datapath_pkg
// Brief   : Shared widths, opcode encoding and strobe bit indices for TRISC.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package trisc_datapath_pkg;

  localparam int C_DATA_W = 8;
  localparam int C_ADDR_W = 5;
  localparam int C_STB_N  = 6;

  typedef enum logic [2:0] {
    OP_NOP0 = 3'b000,
    OP_INCA = 3'b001,
    OP_CLRA = 3'b010,
    OP_LDA  = 3'b011,
    OP_STA  = 3'b100,
    OP_ADD  = 3'b101,
    OP_JMP  = 3'b110,
    OP_NOP7 = 3'b111
  } opcode_e;

  localparam int C_STB_INCA = 0;
  localparam int C_STB_CLRA = 1;
  localparam int C_STB_LDA  = 2;
  localparam int C_STB_STA  = 3;
  localparam int C_STB_ADD  = 4;
  localparam int C_STB_JMP  = 5;

endpackage

`default_nettype wire

// File: rtl/trisc_datapath_decode.sv
//------------------------------------------------------------------------------
// Module  : trisc_decode
// Brief   : Opcode to one-hot instruction strobe decoder (combinational).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trisc_decode
  import trisc_datapath_pkg::*;
#(
  parameter int OPC_W = 3
) (
  input  logic [OPC_W-1:0]   opcode,
  output logic [C_STB_N-1:0] stb
);

  // Unlisted opcodes (the two NOPs) leave every strobe low.
  always_comb begin
    stb = '0;
    case (opcode)
      OPC_W'(OP_INCA): stb[C_STB_INCA] = 1'b1;
      OPC_W'(OP_CLRA): stb[C_STB_CLRA] = 1'b1;
      OPC_W'(OP_LDA):  stb[C_STB_LDA]  = 1'b1;
      OPC_W'(OP_STA):  stb[C_STB_STA]  = 1'b1;
      OPC_W'(OP_ADD):  stb[C_STB_ADD]  = 1'b1;
      OPC_W'(OP_JMP):  stb[C_STB_JMP]  = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/trisc_datapath.sv
//------------------------------------------------------------------------------
// Module  : trisc_datapath
// Brief   : TRISC datapath - PC, IR, MDR, ACC, memory port and opcode strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module trisc_datapath
  import trisc_datapath_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int ADDR_W = C_ADDR_W
) (
  input  logic              clk,
  input  logic              CLRn,
  input  logic              C0,
  input  logic              C1,
  input  logic              C2,
  input  logic              C3,
  input  logic              C4,
  input  logic              C42,
  input  logic              C5,
  input  logic              C6,
  input  logic              C7,
  input  logic              C8,
  input  logic              C9,
  input  logic              C10,
  input  logic              C11,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              INCA,
  output logic              CLRA,
  output logic              LDA,
  output logic              STA,
  output logic              ADD,
  output logic              JMP,
  output logic [DATA_W-1:0] acc,
  output logic              acc_zero,
  output logic              carry
);

  localparam int OPC_W = DATA_W - ADDR_W;

  logic [ADDR_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_ir;
  logic [DATA_W-1:0]  r_mdr;
  logic [DATA_W-1:0]  r_acc;
  logic               r_carry;
  logic               r_src_sel;
  logic [C_STB_N-1:0] r_stb;
  logic [C_STB_N-1:0] w_stb_dec;
  logic [ADDR_W-1:0]  w_ir_addr;
  logic [DATA_W:0]    w_sum;
  logic               w_unused;

  assign w_ir_addr = r_ir[ADDR_W-1:0];
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_mdr};
  assign w_unused  = C6;

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn)   r_pc <= '0;
    else if (C0) r_pc <= '0;
    else if (C1) r_pc <= w_ir_addr;
    else if (C2) r_pc <= r_pc + ADDR_W'(1);
  end

  // C3 steers the captured word: instruction on fetch, operand otherwise.
  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      r_ir  <= '0;
      r_mdr <= '0;
    end else if (C42) begin
      if (C3) r_mdr <= mem_rdata;
      else    r_ir  <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_src_sel <= 1'b0;
    end else begin
      if (C8) begin
        r_acc <= '0;
      end else if (C9) begin
        r_acc <= r_acc + DATA_W'(1);
      end else if (!C11) begin
        if (r_src_sel) begin
          r_acc   <= w_sum[DATA_W-1:0];
          r_carry <= w_sum[DATA_W];
        end else begin
          r_acc   <= r_mdr;
          r_carry <= 1'b0;
        end
      end
      if (C11) r_src_sel <= C10;
    end
  end

  trisc_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opcode (r_ir[DATA_W-1:ADDR_W]),
    .stb    (w_stb_dec)
  );

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn)   r_stb <= '0;
    else if (C7) r_stb <= w_stb_dec;
  end

  assign mem_addr  = C3 ? w_ir_addr : r_pc;
  assign mem_re    = C4 & ~C5;
  assign mem_we    = C4 & C5;
  assign mem_wdata = r_acc;

  assign INCA     = r_stb[C_STB_INCA];
  assign CLRA     = r_stb[C_STB_CLRA];
  assign LDA      = r_stb[C_STB_LDA];
  assign STA      = r_stb[C_STB_STA];
  assign ADD      = r_stb[C_STB_ADD];
  assign JMP      = r_stb[C_STB_JMP];
  assign acc      = r_acc;
  assign acc_zero = (r_acc == '0);
  assign carry    = r_carry;

endmodule

`default_nettype wire
